// File: rtl/crc_serial_param_if.sv
// Serial CRC engine bus: message-side strobes in, serial/parallel CRC out.
// With CRC_CHECK_EN defined the bus also carries the residue-match flag crc_ok.
interface crc_serial_param_if #(
    parameter int CRC_W = 16
);
    logic             load;
    logic             d_valid;
    logic             crc_in;
    logic             d_finish;
    logic             crc_out;
    logic             out_valid;
    logic             busy;
    logic [CRC_W-1:0] crc_value;
`ifdef CRC_CHECK_EN
    logic             crc_ok;

    modport master (
        output load, d_valid, crc_in, d_finish,
        input  crc_out, out_valid, busy, crc_value, crc_ok
    );

    modport slave (
        input  load, d_valid, crc_in, d_finish,
        output crc_out, out_valid, busy, crc_value, crc_ok
    );
`else
    modport master (
        output load, d_valid, crc_in, d_finish,
        input  crc_out, out_valid, busy, crc_value
    );

    modport slave (
        input  load, d_valid, crc_in, d_finish,
        output crc_out, out_valid, busy, crc_value
    );
`endif
endinterface

// File: rtl/crc_serial_param.sv
// Parametrised bit-serial CRC generator/checker (non-reflected, MSB-first).
// Message bits are folded in while d_valid is high; d_finish captures the
// final CRC in parallel and shifts it out MSB-first over CRC_W cycles.
// Optional feature macro: CRC_CHECK_EN adds the registered residue flag crc_ok.
module crc_serial_param #(
    parameter int             CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    crc_serial_param_if.slave    bus
);
    localparam int CNT_W = $clog2(CRC_W) + 1;

    typedef enum logic [1:0] {IDLE, CALC, SHIFT} state_t;

    state_t           state;
    state_t           next_state;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] shift_reg;
    logic [CRC_W-1:0] crc_next;
    logic [CRC_W-1:0] final_crc;
    logic [CNT_W-1:0] cnt;
    logic             fb;
    logic             shift_done;
    logic             crc_out;
    logic             out_valid;
    logic [CRC_W-1:0] crc_value;

    // One LFSR step for the current input bit; final_crc includes a bit
    // that arrives in the same cycle as d_finish.
    always_comb begin
        fb         = crc_reg[CRC_W-1] ^ bus.crc_in;
        crc_next   = crc_reg;
        if (bus.d_valid) begin
            crc_next = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        final_crc  = crc_next ^ XOR_OUT;
        shift_done = (cnt == CNT_W'(CRC_W));
    end

    // Next-state selection: load overrides everything, including a running shift.
    always_comb begin
        next_state = state;
        if (bus.load) begin
            next_state = CALC;
        end else begin
            case (state)
                CALC:    if (bus.d_finish) next_state = SHIFT;
                SHIFT:   if (shift_done)   next_state = IDLE;
                default: next_state = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Datapath: CRC accumulation, capture at finish, and the serial shifter.
    // The first CRC bit is driven straight from the finish cycle so it is
    // valid the cycle after d_finish; cnt counts bits already presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg   <= INIT;
            shift_reg <= '0;
            cnt       <= '0;
            crc_out   <= 1'b0;
            out_valid <= 1'b0;
            crc_value <= '0;
        end else if (bus.load) begin
            crc_reg   <= INIT;
            cnt       <= '0;
            crc_out   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    if (bus.d_finish) begin
                        crc_reg   <= crc_next;
                        crc_value <= final_crc;
                        crc_out   <= final_crc[CRC_W-1];
                        shift_reg <= final_crc << 1;
                        out_valid <= 1'b1;
                        cnt       <= CNT_W'(1);
                    end else if (bus.d_valid) begin
                        crc_reg <= crc_next;
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        out_valid <= 1'b0;
                        crc_out   <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        crc_out   <= shift_reg[CRC_W-1];
                        shift_reg <= shift_reg << 1;
                        cnt       <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CRC_CHECK_EN
    logic crc_ok;

    // Residue flag for checking received message+CRC streams.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           crc_ok <= 1'b0;
        else if (bus.load) crc_ok <= 1'b0;
        else               crc_ok <= (state == CALC) && (crc_reg == RESIDUE);
    end

    assign bus.crc_ok = crc_ok;
`endif

    assign bus.crc_out   = crc_out;
    assign bus.out_valid = out_valid;
    assign bus.crc_value = crc_value;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_crc_serial_param.sv
// Self-checking bench for crc_serial_param: a CRC-16/CCITT-FALSE instance and
// a CRC-8 (poly 0x07) instance. Expected serial bits go into scoreboard queues
// when d_finish is driven and are popped whenever out_valid is seen.
module tb_crc_serial_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    string msg = "123456789";

    logic exp_q[$];
    logic exp8_q[$];

    crc_serial_param_if #(.CRC_W(16)) bus();
    crc_serial_param_if #(.CRC_W(8))  bus8();

    crc_serial_param dut (.clk(clk), .rst(rst), .bus(bus));

    crc_serial_param #(
        .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00)
    ) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    // Scoreboard for the 16-bit instance.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL crc_out16 unexpected bit: got %0b, none expected", bus.crc_out);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if (bus.crc_out !== e) begin
                    failures++;
                    $display("[TB] FAIL crc_out16 bit: got %0b, expected %0b", bus.crc_out, e);
                end
            end
        end
    end

    // Scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        if (bus8.out_valid) begin
            checks++;
            if (exp8_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL crc_out8 unexpected bit: got %0b, none expected", bus8.crc_out);
            end else begin
                logic e;
                e = exp8_q.pop_front();
                if (bus8.crc_out !== e) begin
                    failures++;
                    $display("[TB] FAIL crc_out8 bit: got %0b, expected %0b", bus8.crc_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.d_valid = 1'b1;
        bus.crc_in  = b;
        tick();
        bus.d_valid = 1'b0;
        bus.crc_in  = 1'b0;
    endtask

    // Sends the first nbits of the ASCII message; flip_idx inverts one bit (-1 = none).
    task automatic send_msg(input int nbits, input int gap, input int flip_idx);
        int k;
        byte c;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            c = msg[i];
            for (int j = 7; j >= 0; j--) begin
                if (k < nbits) begin
                    send_bit(c[j] ^ (k == flip_idx));
                    repeat (gap) tick();
                end
                k++;
            end
        end
    endtask

    task automatic do_finish(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) exp_q.push_back(v[i]);
        bus.d_finish = 1'b1;
        tick();
        bus.d_finish = 1'b0;
    endtask

    task automatic wait_idle(output bit ok, output int nvalid);
        ok = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({bus.crc_out, bus.out_valid, bus.busy} !== 3'b000 || bus.crc_value !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: got out=%0b ov=%0b busy=%0b val=%h, expected 0 0 0 0000",
                     bus.crc_out, bus.out_valid, bus.busy, bus.crc_value);
        end
        rst = 1'b0;
        tick();
        // Asynchronous reset in the middle of shifting, away from a clock edge.
        do_load();
        do_finish(16'hFFFF);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.crc_out, bus.out_valid, bus.busy} !== 3'b000 || bus.crc_value !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_shift: got out=%0b ov=%0b busy=%0b val=%h, expected 0 0 0 0000",
                     bus.crc_out, bus.out_valid, bus.busy, bus.crc_value);
        end
        exp_q.delete();
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic run_and_check(input string name, input logic [15:0] expv);
        bit ok;
        int nvalid;
        wait_idle(ok, nvalid);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s timeout: busy still %0b after 40 cycles, expected 0", name, bus.busy);
        end
        checks++;
        if (bus.crc_value !== expv) begin
            failures++;
            $display("[TB] FAIL %s crc_value: got %h, expected %h", name, bus.crc_value, expv);
        end
        checks++;
        if (nvalid != 16 || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s shift_len: got %0d valid cycles (%0d bits left), expected 16 (0)",
                     name, nvalid, exp_q.size());
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.crc_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s after_shift: got ov=%0b out=%0b, expected 0 0",
                     name, bus.out_valid, bus.crc_out);
        end
        exp_q.delete();
    endtask

    task automatic test_ascii();
        do_load();
        send_msg(72, 0, -1);
        do_finish(16'h29B1);
        run_and_check("ascii", 16'h29B1);
    endtask

    task automatic test_zero_length();
        do_load();
        do_finish(16'hFFFF);
        run_and_check("zero_len", 16'hFFFF);
    endtask

    task automatic test_gapped();
        do_load();
        send_msg(72, 1, -1);
        do_finish(16'h29B1);
        run_and_check("gapped", 16'h29B1);
    endtask

    // Last message bit arrives together with d_finish and must still be folded in.
    task automatic test_fold();
        do_load();
        send_msg(71, 0, -1);
        bus.d_valid = 1'b1;
        bus.crc_in  = 1'b1;
        do_finish(16'h29B1);
        bus.d_valid = 1'b0;
        bus.crc_in  = 1'b0;
        run_and_check("fold", 16'h29B1);
    endtask

    task automatic test_load_abort();
        do_load();
        send_msg(72, 0, -1);
        do_finish(16'h29B1);
        repeat (4) tick();
        do_load();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_state: got ov=%0b busy=%0b, expected 0 1", bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.crc_value !== 16'h29B1) begin
            failures++;
            $display("[TB] FAIL abort_hold: got %h, expected 29b1", bus.crc_value);
        end
        exp_q.delete();
        #6;
        do_finish(16'hFFFF);
        run_and_check("after_abort", 16'hFFFF);
    endtask

    task automatic test_idle_ignore();
        send_bit(1'b1);
        bus.d_finish = 1'b1;
        tick();
        bus.d_finish = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.crc_value !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL idle_ignore: got busy=%0b ov=%0b val=%h, expected 0 0 ffff",
                     bus.busy, bus.out_valid, bus.crc_value);
        end
        #6;
        // load beats d_finish in the same cycle.
        bus.load     = 1'b1;
        bus.d_finish = 1'b1;
        tick();
        bus.load     = 1'b0;
        bus.d_finish = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_priority: got busy=%0b ov=%0b, expected 1 0", bus.busy, bus.out_valid);
        end
        #6;
        send_msg(72, 0, -1);
        do_finish(16'h29B1);
        run_and_check("after_priority", 16'h29B1);
    endtask

`ifdef CRC_CHECK_EN
    task automatic test_check();
        logic [15:0] c;
        c = 16'h29B1;
        do_load();
        @(negedge clk);
        checks++;
        if (bus.crc_ok !== 1'b0) begin
            failures++;
            $display("[TB] FAIL crc_ok_start: got %0b, expected 0", bus.crc_ok);
        end
        #6;
        send_msg(72, 0, -1);
        for (int i = 15; i >= 0; i--) send_bit(c[i]);
        tick();
        checks++;
        if (bus.crc_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL crc_ok_good: got %0b, expected 1", bus.crc_ok);
        end
        do_load();
        send_msg(72, 0, 13);
        for (int i = 15; i >= 0; i--) send_bit(c[i]);
        tick();
        checks++;
        if (bus.crc_ok !== 1'b0) begin
            failures++;
            $display("[TB] FAIL crc_ok_flipped: got %0b, expected 0", bus.crc_ok);
        end
    endtask
`endif

    task automatic test_crc8();
        bit ok;
        byte c;
        logic [7:0] v;
        v = 8'hF4;
        bus8.load = 1'b1;
        tick();
        bus8.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            c = msg[i];
            for (int j = 7; j >= 0; j--) begin
                bus8.d_valid = 1'b1;
                bus8.crc_in  = c[j];
                tick();
            end
        end
        bus8.d_valid = 1'b0;
        bus8.crc_in  = 1'b0;
        for (int i = 7; i >= 0; i--) exp8_q.push_back(v[i]);
        bus8.d_finish = 1'b1;
        tick();
        bus8.d_finish = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus8.busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || exp8_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL crc8_done: got idle=%0b bits_left=%0d, expected 1 0", ok, exp8_q.size());
        end
        checks++;
        if (bus8.crc_value !== 8'hF4) begin
            failures++;
            $display("[TB] FAIL crc8_value: got %h, expected f4", bus8.crc_value);
        end
        exp8_q.delete();
    endtask

    initial begin
        bus.load = 0;  bus.d_valid = 0;  bus.crc_in = 0;  bus.d_finish = 0;
        bus8.load = 0; bus8.d_valid = 0; bus8.crc_in = 0; bus8.d_finish = 0;
        test_reset();
        test_ascii();
        test_zero_length();
        test_gapped();
        test_fold();
        test_load_abort();
        test_idle_ignore();
`ifdef CRC_CHECK_EN
        test_check();
`endif
        test_crc8();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
